// File: rtl/fc_layer.sv
// Fully-connected output stage: accumulates one pooled frame against a weight ROM,
// adds bias, scans for the argmax and presents all scores with a one-cycle valid pulse.
module fc_layer #(
    parameter int IN_W    = 22,
    parameter int W_W     = 9,
    parameter int IN_NUM  = 196,
    parameter int NUM_OUT = 10,
    parameter int ACC_W   = 40,
    parameter int IDX_W   = 8,
    parameter int CLS_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [IN_W-1:0]          in_data,
    output logic [IDX_W-1:0]         w_addr,
    input  logic [NUM_OUT*W_W-1:0]   w_data,
    input  logic [NUM_OUT*W_W-1:0]   bias,
    output logic                     out_valid,
    output logic [NUM_OUT*ACC_W-1:0] out_data,
    output logic [CLS_W-1:0]         out_index,
    output logic                     busy,
    output logic                     drop_err
);

    localparam int PROD_W = IN_W + W_W;

    typedef enum logic [1:0] {S_ACC, S_BIAS, S_SCAN, S_DONE} state_t;

    state_t                   state, state_nxt;
    logic [IDX_W-1:0]         cnt;
    logic [CLS_W-1:0]         scan_idx;
    logic signed [ACC_W-1:0]  acc [NUM_OUT];
    logic signed [PROD_W-1:0] prod [NUM_OUT];
    logic signed [ACC_W-1:0]  best;
    logic signed [ACC_W-1:0]  scan_val;
    logic [CLS_W-1:0]         best_idx;
    logic                     take;
    logic                     last_sample;
    logic                     scan_last;
    logic                     scan_gt;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    function automatic logic signed [ACC_W-1:0] sext_coef(input logic signed [W_W-1:0] c);
        return {{(ACC_W-W_W){c[W_W-1]}}, c};
    endfunction

    function automatic logic signed [PROD_W-1:0] mul_sample(input logic [IN_W-1:0] a,
                                                            input logic [W_W-1:0]  b);
        logic signed [PROD_W-1:0] a_ext;
        logic signed [PROD_W-1:0] b_ext;
        a_ext = {{W_W{a[IN_W-1]}}, a};
        b_ext = {{IN_W{b[W_W-1]}}, b};
        return a_ext * b_ext;
    endfunction

    assign busy        = (state != S_ACC);
    assign take        = in_valid && (state == S_ACC);
    assign last_sample = (cnt == IDX_W'(IN_NUM - 1));
    assign scan_last   = (scan_idx == CLS_W'(NUM_OUT - 1));
    assign scan_val    = acc[scan_idx];
    // Index 0 seeds the running best; later entries must be strictly greater, so ties keep the lowest index.
    assign scan_gt     = (scan_idx == '0) || (scan_val > best);
    assign w_addr      = cnt;

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            prod[k] = mul_sample(in_data, w_data[k*W_W +: W_W]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_ACC;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_ACC:   if (take && last_sample) state_nxt = S_BIAS;
            S_BIAS:  state_nxt = S_SCAN;
            S_SCAN:  if (scan_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_ACC;
            default: state_nxt = S_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            scan_idx  <= '0;
            drop_err  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= (state == S_SCAN) && scan_last;
            if (take) cnt <= last_sample ? '0 : cnt + IDX_W'(1);
            if (in_valid && busy) drop_err <= 1'b1;
            if (state == S_SCAN) scan_idx <= scan_last ? '0 : scan_idx + CLS_W'(1);
        end
    end

    // Results are latched on the final scan step so they are stable while out_valid is high in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NUM_OUT; k++) acc[k] <= '0;
            best      <= '0;
            best_idx  <= '0;
            out_data  <= '0;
            out_index <= '0;
        end else begin
            case (state)
                S_ACC: begin
                    if (take) begin
                        for (int k = 0; k < NUM_OUT; k++) acc[k] <= acc[k] + sext_prod(prod[k]);
                    end
                end
                S_BIAS: begin
                    for (int k = 0; k < NUM_OUT; k++) begin
                        acc[k] <= acc[k] + sext_coef(bias[k*W_W +: W_W]);
                    end
                end
                S_SCAN: begin
                    if (scan_gt) begin
                        best     <= scan_val;
                        best_idx <= scan_idx;
                    end
                    if (scan_last) begin
                        out_index <= scan_gt ? scan_idx : best_idx;
                        for (int k = 0; k < NUM_OUT; k++) out_data[k*ACC_W +: ACC_W] <= acc[k];
                    end
                end
                S_DONE: begin
                    for (int k = 0; k < NUM_OUT; k++) acc[k] <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
